// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: load/store width codes and the MEM-stage
// debug-port state encoding.
package mips_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b11;

    typedef enum logic [1:0] {
        DBG_IDLE = 2'd0,
        DBG_READ = 2'd1,
        DBG_ACK  = 2'd2
    } dbg_state_e;

endpackage

// File: rtl/data_memory.sv
// Byte-lane data RAM: one lane-enabled write port and two asynchronous word
// read ports (pipeline and debug). Contents are intentionally not reset.
module data_memory #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10
) (
    input  logic                 clk,
    input  logic [3:0]           i_we,
    input  logic [NB_ADDR-3:0]   i_waddr,
    input  logic [NB_DATA-1:0]   i_wdata,
    input  logic [NB_ADDR-3:0]   i_raddr,
    output logic [NB_DATA-1:0]   o_rdata,
    input  logic [NB_ADDR-3:0]   i_dbg_raddr,
    output logic [NB_DATA-1:0]   o_dbg_rdata
);
    localparam int DEPTH = 2 ** (NB_ADDR - 2);

    logic [NB_DATA-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (i_we[l]) begin
                mem_q[i_waddr][8*l +: 8] <= i_wdata[8*l +: 8];
            end
        end
    end

    assign o_rdata     = mem_q[i_raddr];
    assign o_dbg_rdata = mem_q[i_dbg_raddr];

endmodule

// File: rtl/memory_access.sv
// MIPS MEM stage: little-endian byte/half/word loads and stores, MEM/WB
// register, and a four-phase debug read port usable while the core is halted.
module memory_access
    import mips_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_stall,
    input  logic                 i_halt,
    input  logic [NB_DATA-1:0]   i_result,
    input  logic [NB_DATA-1:0]   i_data4Mem,
    input  logic [1:0]           i_width,
    input  logic                 i_sign_flag,
    input  logic                 i_mem2reg,
    input  logic                 i_memRead,
    input  logic                 i_memWrite,
    input  logic                 i_regWrite,
    input  logic [4:0]           i_write_reg,
    output logic                 o_mem2reg,
    output logic                 o_regWrite,
    output logic [4:0]           o_write_reg,
    output logic [NB_DATA-1:0]   o_alu_result,
    output logic [NB_DATA-1:0]   o_read_data,
    output logic                 o_misaligned,
    input  logic                 i_dbg_req,
    input  logic [NB_ADDR-3:0]   i_dbg_addr,
    output logic                 o_dbg_ack,
    output logic [NB_DATA-1:0]   o_dbg_data
);
    logic [NB_ADDR-1:0] addr;
    logic [1:0]         lane;
    logic [NB_DATA-1:0] rd_word;
    logic [NB_DATA-1:0] dbg_word;
    logic [NB_DATA-1:0] wdata;
    logic [3:0]         lane_en;
    logic [3:0]         we;
    logic               width_mis;
    logic               misaligned_d;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [NB_DATA-1:0] ext_val;
    logic [NB_DATA-1:0] read_data_d;
    logic               unused_addr_bits;

    logic               mem2reg_q, regWrite_q, misaligned_q;
    logic [4:0]         write_reg_q;
    logic [NB_DATA-1:0] alu_result_q, read_data_q;

    dbg_state_e         dbg_state_q;
    logic [NB_ADDR-3:0] dbg_addr_q;
    logic               dbg_ack_q;
    logic [NB_DATA-1:0] dbg_data_q;

    // Upper address bits are dropped so accesses wrap modulo the RAM size.
    assign addr             = i_result[NB_ADDR-1:0];
    assign lane             = addr[1:0];
    assign unused_addr_bits = ^i_result[NB_DATA-1:NB_ADDR];

    always_comb begin
        width_mis = 1'b0;
        lane_en   = 4'b1111;
        wdata     = i_data4Mem;
        case (i_width)
            W_BYTE: begin
                lane_en = 4'b0001 << lane;
                wdata   = {4{i_data4Mem[7:0]}};
            end
            W_HALF: begin
                width_mis = addr[0];
                lane_en   = addr[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{i_data4Mem[15:0]}};
            end
            default: width_mis = |lane;
        endcase
    end

    assign misaligned_d = (i_memRead | i_memWrite) & width_mis;
    assign we = {4{i_memWrite & ~i_stall & ~i_halt & ~width_mis}} & lane_en;

    data_memory #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) u_ram (
        .clk         (clk),
        .i_we        (we),
        .i_waddr     (addr[NB_ADDR-1:2]),
        .i_wdata     (wdata),
        .i_raddr     (addr[NB_ADDR-1:2]),
        .o_rdata     (rd_word),
        .i_dbg_raddr (dbg_addr_q),
        .o_dbg_rdata (dbg_word)
    );

    assign byte_sel = rd_word[8*lane +: 8];
    assign half_sel = addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ext_val = rd_word;
        case (i_width)
            W_BYTE:  ext_val = {{24{i_sign_flag & byte_sel[7]}}, byte_sel};
            W_HALF:  ext_val = {{16{i_sign_flag & half_sel[15]}}, half_sel};
            default: ext_val = rd_word;
        endcase
    end

    assign read_data_d = (i_memRead & ~width_mis) ? ext_val : '0;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            mem2reg_q    <= 1'b0;
            regWrite_q   <= 1'b0;
            write_reg_q  <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            misaligned_q <= 1'b0;
        end else if (!(i_stall || i_halt)) begin
            mem2reg_q    <= i_mem2reg;
            regWrite_q   <= i_regWrite;
            write_reg_q  <= i_write_reg;
            alu_result_q <= i_result;
            read_data_q  <= read_data_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Losing halt aborts any debug transaction in progress.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            dbg_state_q <= DBG_IDLE;
            dbg_addr_q  <= '0;
            dbg_ack_q   <= 1'b0;
            dbg_data_q  <= '0;
        end else begin
            case (dbg_state_q)
                DBG_IDLE: begin
                    dbg_ack_q <= 1'b0;
                    if (i_dbg_req && i_halt) begin
                        dbg_state_q <= DBG_READ;
                        dbg_addr_q  <= i_dbg_addr;
                    end
                end
                DBG_READ: begin
                    if (!i_halt) begin
                        dbg_state_q <= DBG_IDLE;
                        dbg_ack_q   <= 1'b0;
                    end else begin
                        dbg_state_q <= DBG_ACK;
                        dbg_data_q  <= dbg_word;
                        dbg_ack_q   <= 1'b1;
                    end
                end
                DBG_ACK: begin
                    if (!i_halt || !i_dbg_req) begin
                        dbg_state_q <= DBG_IDLE;
                        dbg_ack_q   <= 1'b0;
                    end
                end
                default: begin
                    dbg_state_q <= DBG_IDLE;
                    dbg_ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem2reg    = mem2reg_q;
    assign o_regWrite   = regWrite_q;
    assign o_write_reg  = write_reg_q;
    assign o_alu_result = alu_result_q;
    assign o_read_data  = read_data_q;
    assign o_misaligned = misaligned_q;
    assign o_dbg_ack    = dbg_ack_q;
    assign o_dbg_data   = dbg_data_q;

endmodule

// File: tb/tb_memory_access.sv
// Randomized bench for memory_access: a byte-array reference model predicts
// the MEM/WB outputs each cycle; directed literals pin loads, stores and debug.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        i_rst, i_stall, i_halt;
    logic [31:0] i_result, i_data4Mem;
    logic [1:0]  i_width;
    logic        i_sign_flag, i_mem2reg, i_memRead, i_memWrite, i_regWrite;
    logic [4:0]  i_write_reg;
    logic        o_mem2reg, o_regWrite, o_misaligned;
    logic [4:0]  o_write_reg;
    logic [31:0] o_alu_result, o_read_data;
    logic        i_dbg_req;
    logic [7:0]  i_dbg_addr;
    logic        o_dbg_ack;
    logic [31:0] o_dbg_data;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    logic [7:0]  mem_m [1024];
    logic        exp_mem2reg, exp_regWrite, exp_mis;
    logic [4:0]  exp_wreg;
    logic [31:0] exp_alu, exp_rd;

    always #5 clk = ~clk;

    memory_access #(.NB_DATA(32), .NB_ADDR(10)) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_stall      (i_stall),
        .i_halt       (i_halt),
        .i_result     (i_result),
        .i_data4Mem   (i_data4Mem),
        .i_width      (i_width),
        .i_sign_flag  (i_sign_flag),
        .i_mem2reg    (i_mem2reg),
        .i_memRead    (i_memRead),
        .i_memWrite   (i_memWrite),
        .i_regWrite   (i_regWrite),
        .i_write_reg  (i_write_reg),
        .o_mem2reg    (o_mem2reg),
        .o_regWrite   (o_regWrite),
        .o_write_reg  (o_write_reg),
        .o_alu_result (o_alu_result),
        .o_read_data  (o_read_data),
        .o_misaligned (o_misaligned),
        .i_dbg_req    (i_dbg_req),
        .i_dbg_addr   (i_dbg_addr),
        .o_dbg_ack    (o_dbg_ack),
        .o_dbg_data   (o_dbg_data)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic is_aligned(input logic [31:0] res, input logic [1:0] w);
        return (int'(res[9:0]) % nbytes(w)) == 0;
    endfunction

    // Little-endian gather of n bytes, then extend from the top loaded bit.
    function automatic logic [31:0] ref_load(input logic [31:0] res, input logic [1:0] w, input logic s);
        int a = int'(res[9:0]);
        int n = nbytes(w);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(mem_m[a+i]) << (8*i));
        if (s && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        return v[31:0];
    endfunction

    always @(posedge clk) begin
        if (i_rst) begin
            exp_mem2reg  <= 1'b0;
            exp_regWrite <= 1'b0;
            exp_wreg     <= 5'd0;
            exp_alu      <= 32'd0;
            exp_rd       <= 32'd0;
            exp_mis      <= 1'b0;
        end else if (!i_stall && !i_halt) begin
            exp_mem2reg  <= i_mem2reg;
            exp_regWrite <= i_regWrite;
            exp_wreg     <= i_write_reg;
            exp_alu      <= i_result;
            exp_rd       <= (i_memRead && is_aligned(i_result, i_width))
                            ? ref_load(i_result, i_width, i_sign_flag) : 32'd0;
            exp_mis      <= (i_memRead || i_memWrite) && !is_aligned(i_result, i_width);
            if (i_memWrite && is_aligned(i_result, i_width)) begin
                for (int i = 0; i < nbytes(i_width); i++)
                    mem_m[int'(i_result[9:0]) + i] <= i_data4Mem[8*i +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("alu_result", o_alu_result, exp_alu);
            cmp("read_data", o_read_data, exp_rd);
            cmp("misaligned", 32'(o_misaligned), 32'(exp_mis));
            cmp("mem2reg", 32'(o_mem2reg), 32'(exp_mem2reg));
            cmp("regWrite", 32'(o_regWrite), 32'(exp_regWrite));
            cmp("write_reg", 32'(o_write_reg), 32'(exp_wreg));
        end
    end

    task automatic drive(input logic [31:0] res, input logic [31:0] dat, input logic [1:0] w,
                         input logic s, input logic rd, input logic wr);
        i_result    = res;
        i_data4Mem  = dat;
        i_width     = w;
        i_sign_flag = s;
        i_memRead   = rd;
        i_memWrite  = wr;
        i_mem2reg   = rd;
        i_regWrite  = 1'($urandom);
        i_write_reg = 5'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        i_rst = 1'b1; i_stall = 1'b0; i_halt = 1'b0;
        i_result = '0; i_data4Mem = '0; i_width = 2'b11; i_sign_flag = 1'b0;
        i_mem2reg = 1'b0; i_memRead = 1'b0; i_memWrite = 1'b0; i_regWrite = 1'b0;
        i_write_reg = '0; i_dbg_req = 1'b0; i_dbg_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_alu", o_alu_result, 32'd0);
        cmp("rst_rd", o_read_data, 32'd0);
        cmp("rst_mis", 32'(o_misaligned), 32'd0);
        cmp("rst_regWrite", 32'(o_regWrite), 32'd0);
        cmp("rst_dbg_ack", 32'(o_dbg_ack), 32'd0);
        cmp("rst_dbg_data", o_dbg_data, 32'd0);
        i_rst = 1'b0;
        chk_en = 1'b1;

        // Give every RAM word a known value before any load.
        for (int w = 0; w < 256; w++) drive(32'(w*4), $urandom, 2'b11, 1'b0, 1'b0, 1'b1);

        drive(32'h10, 32'hDEADBEEF, 2'b11, 1'b0, 1'b0, 1'b1);
        drive(32'h10, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0);
        cmp("lit_word_load", o_read_data, 32'hDEADBEEF);
        cmp("lit_word_mis", 32'(o_misaligned), 32'd0);
        drive(32'h13, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0);
        cmp("lit_sbyte", o_read_data, 32'hFFFFFFDE);
        drive(32'h13, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
        cmp("lit_ubyte", o_read_data, 32'h000000DE);
        drive(32'h12, 32'h0, 2'b01, 1'b1, 1'b1, 1'b0);
        cmp("lit_shalf", o_read_data, 32'hFFFFDEAD);

        i_halt = 1'b1; i_dbg_addr = 8'd4; i_dbg_req = 1'b1;
        tick();
        cmp("dbg_read_noack", 32'(o_dbg_ack), 32'd0);
        tick();
        cmp("dbg_ack", 32'(o_dbg_ack), 32'd1);
        cmp("dbg_data", o_dbg_data, 32'hDEADBEEF);
        i_dbg_req = 1'b0;
        tick();
        cmp("dbg_ack_drop", 32'(o_dbg_ack), 32'd0);
        i_halt = 1'b0; i_dbg_req = 1'b1;
        repeat (3) begin
            tick();
            cmp("dbg_nohalt_noack", 32'(o_dbg_ack), 32'd0);
        end
        i_dbg_req = 1'b0;
        tick();
        i_halt = 1'b1; i_dbg_req = 1'b1;
        tick(); tick();
        cmp("dbg_ack2", 32'(o_dbg_ack), 32'd1);
        i_halt = 1'b0;
        tick();
        cmp("dbg_halt_abort", 32'(o_dbg_ack), 32'd0);
        i_dbg_req = 1'b0;

        drive(32'h11, 32'h55, 2'b00, 1'b0, 1'b0, 1'b1);
        drive(32'h10, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0);
        cmp("lit_partial", o_read_data, 32'hDEAD55EF);
        drive(32'h12, 32'h12345678, 2'b11, 1'b0, 1'b0, 1'b1);
        cmp("lit_mis_store", 32'(o_misaligned), 32'd1);
        drive(32'h10, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0);
        cmp("lit_mis_nowrite", o_read_data, 32'hDEAD55EF);
        drive(32'h402, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0);
        cmp("lit_wrap_rd", o_read_data, 32'h0);
        cmp("lit_wrap_mis", 32'(o_misaligned), 32'd1);
        i_stall = 1'b1;
        drive(32'h10, 32'hCAFEF00D, 2'b11, 1'b0, 1'b0, 1'b1);
        cmp("lit_stall_hold", o_alu_result, 32'h402);
        i_stall = 1'b0;
        drive(32'h10, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0);
        cmp("lit_stall_nowrite", o_read_data, 32'hDEAD55EF);

        for (int c = 0; c < 3000; c++) begin
            logic [31:0] r;
            r = $urandom;
            i_stall = ($urandom_range(0, 7) == 0);
            i_halt  = ($urandom_range(0, 15) == 0);
            drive(r[3] ? $urandom : {24'd0, r[31:24]}, $urandom, 2'($urandom), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 2) == 0));
        end
        i_stall = 1'b0; i_halt = 1'b0;
        drive(32'h0, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_access.md
# memory_access

Memory-access (MEM) stage of the 5-stage MIPS pipeline. It receives the EX/MEM pipeline register from the execute stage, which supplies the ALU result used as the byte address, store data, width, sign and control bits. It performs byte, halfword and word loads and stores on a little-endian data RAM and drives the MEM/WB pipeline register. While the core is halted, a four-phase debug read port gives the debug unit access to the RAM.

## Interface
- NB_DATA, 32, data path width
- NB_ADDR, 10, byte-address bits used; RAM depth = 2**(NB_ADDR-2) words
- clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_stall  in  1  hold MEM/WB register, suppress store
- i_halt  in  1  core halted: hold MEM/WB, suppress store, enable debug port
- i_result  in  NB_DATA  ALU result; the byte address for loads and stores
- i_data4Mem  in  NB_DATA  store data
- i_width  in  2  00 byte, 01 half, 11 word, 10 treated as word
- i_sign_flag  in  1  1 = sign-extend loads, 0 = zero-extend
- i_mem2reg, i_memRead, i_memWrite, i_regWrite  in  1 each  control bits
- i_write_reg  in  5  destination register
- o_mem2reg, o_regWrite  out  1 each  registered control
- o_write_reg  out  5  registered destination
- o_alu_result  out  NB_DATA  registered i_result
- o_read_data  out  NB_DATA  registered, extended load data
- o_misaligned  out  1  registered; 1 for the instruction in MEM/WB if its access was misaligned
- i_dbg_req  in  1  debug read request (four-phase)
- i_dbg_addr  in  NB_ADDR-2  debug word address
- o_dbg_ack  out  1  debug acknowledge
- o_dbg_data  out  NB_DATA  debug read word

## Operation
**Addressing**
- Byte address = i_result[NB_ADDR-1:0]. Upper bits are ignored, so addresses wrap modulo the RAM size.
- Word index = address[NB_ADDR-1:2]. Lane = address[1:0].

**Alignment**
- A halfword access is misaligned when address[0]=1.
- A word access is misaligned when address[1:0]≠0.
- A misaligned store writes nothing.
- A misaligned load returns 0.
- o_misaligned=1 in both cases.

**Stores** (i_memWrite & !i_stall & !i_halt & aligned)
- Byte: writes i_data4Mem[7:0] to lane address[1:0].
- Half: writes [15:0] to lanes {address[1],0} and {address[1],1}.
- Word: writes all four lanes.
- Other lanes are unchanged.

**Loads** (i_memRead)
- The selected byte or half is right-justified in o_read_data.
- Sign-extended if i_sign_flag=1, else zero-extended.
- When i_memRead=0, o_read_data=0.

**MEM/WB register**
- Loads all registered outputs every cycle unless i_stall or i_halt is high; then it holds.

**Debug FSM (IDLE, READ, ACK)**
- IDLE → READ: when i_dbg_req & i_halt. i_dbg_addr is captured.
- READ → ACK: always. o_dbg_data is loaded from RAM[captured addr].
- ACK: o_dbg_ack=1 and o_dbg_data is stable. Leaves to IDLE when i_dbg_req=0.
- If i_halt falls in READ or ACK: go to IDLE, o_dbg_ack=0.
- If i_dbg_req is high while i_halt is low: ignored, stays in IDLE.

## Timing
- Reset: all registered outputs are 0; o_dbg_data=0; FSM is IDLE. RAM contents are not reset.
- Reset has priority over stall, halt and debug.
- Latency: EX/MEM inputs in cycle N appear on the MEM/WB outputs after edge N+1.
- Store takes effect at edge N+1. A load in cycle N+1 to the same address sees the new data, because the RAM write precedes the next read.
- Debug: request sampled at edge k, READ after k, o_dbg_ack=1 after k+1, o_dbg_ack=0 one edge after i_dbg_req falls.
- Debug reads never modify the RAM. Pipeline stores cannot occur while halted, so the two never collide.

## Structure
- Shared package mips_pkg holds:
  - width codes W_BYTE=2'b00, W_HALF=2'b01, W_WORD=2'b11
  - debug FSM state encoding
- Sub-module data_memory:
  - byte-lane RAM
  - one write port with 4-bit lane enable
  - two asynchronous word read ports: pipeline and debug
- Lane select, extension and misalignment logic stay in memory_access.

## Test plan
- Word store/load: store 0xDEADBEEF at address 0x10, then load word from 0x10 → o_read_data=0xDEADBEEF one cycle after the load; o_misaligned=0.
- Byte extension: with 0xDEADBEEF at 0x10:
  - signed byte from 0x13 → 0xFFFFFFDE
  - unsigned byte from 0x13 → 0x000000DE
  - signed half from 0x12 → 0xFFFFDEAD
- Partial store: store byte 0x55 at 0x11 over 0xDEADBEEF → word from 0x10 reads 0xDEAD55EF.
- Misalignment and wrap:
  - store word to 0x12 → RAM unchanged, o_misaligned=1
  - load word from 0x402 (NB_ADDR=10) → wraps to word 0, returns 0, o_misaligned=1
- Stall/halt: assert i_stall during a store → no write, MEM/WB outputs hold their previous values; release → next instruction proceeds normally.
- Debug: with i_halt=1, request word 4 holding 0xDEADBEEF → o_dbg_ack rises 2 cycles later with o_dbg_data=0xDEADBEEF and falls 1 cycle after i_dbg_req drops. A request with i_halt=0 gets no ack. Dropping i_halt while in ACK clears the ack.
